// File: rtl/imem_responder_if.sv
// Command/data-phase bus between the fetch stage (master) and the instruction memory (slave).
// One command channel (reads and writes) and one read-data channel.
interface imem_responder_if #(
    parameter int IDATAW = 128,
    parameter int ISIZEW = 8,
    parameter int IADDRW = 32
);
    logic              imem_valid;
    logic              imem_ready;
    logic [IADDRW-1:0] imem_address;
    logic              imem_wr_en;
    logic [IDATAW-1:0] imem_wr_data;
    logic [ISIZEW-1:0] imem_wr_size;
    logic              imem_dp_valid;
    logic              imem_dp_ready;
    logic [IDATAW-1:0] imem_dp_read_data;

    modport master (
        output imem_valid,
        output imem_address,
        output imem_wr_en,
        output imem_wr_data,
        output imem_wr_size,
        output imem_dp_ready,
        input  imem_ready,
        input  imem_dp_valid,
        input  imem_dp_read_data
    );

    modport slave (
        input  imem_valid,
        input  imem_address,
        input  imem_wr_en,
        input  imem_wr_data,
        input  imem_wr_size,
        input  imem_dp_ready,
        output imem_ready,
        output imem_dp_valid,
        output imem_dp_read_data
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-granular line writes, in-order reads returned
// after a fixed latency through a small pending queue of line snapshots.
module imem_responder #(
    parameter int IDATAW     = 128,
    parameter int ISIZEW     = 8,
    parameter int IADDRW     = 32,
    parameter int LINES_LOG2 = 10,
    parameter int QDEPTH     = 4,
    parameter int LATENCY    = 3
) (
    input  logic             clk,
    input  logic             reset,
    imem_responder_if.slave  imem
);

    localparam int NBYTES = IDATAW / 8;
    localparam int QPTRW  = $clog2(QDEPTH);
    localparam int CNTW   = QPTRW + 1;
    localparam int LATW   = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_t;

    logic [IDATAW-1:0]     line_mem [2**LINES_LOG2];
    logic [IDATAW-1:0]     q_data [QDEPTH];
    logic [QPTRW-1:0]      wr_ptr;
    logic [QPTRW-1:0]      rd_ptr;
    logic [CNTW-1:0]       count;
    state_t                state;
    state_t                state_nxt;
    logic [LATW-1:0]       lat_cnt;
    logic [LATW-1:0]       lat_nxt;
    logic [LINES_LOG2-1:0] line_idx;
    logic [3:0]            wr_off;
    logic [5:0]            wr_len;
    logic [5:0]            wr_end;
    logic [NBYTES-1:0]     wr_be;
    logic [IDATAW-1:0]     wr_shifted;
    logic                  cmd_accept;
    logic                  push;
    logic                  wr_accept;
    logic                  resp_valid;
    logic                  pop;
    logic                  unused_addr_bits;

    assign line_idx         = imem.imem_address[LINES_LOG2+3:4];
    assign unused_addr_bits = ^imem.imem_address[IADDRW-1:LINES_LOG2+4];
    assign wr_off           = imem.imem_address[3:0];

    assign imem.imem_ready = (count < CNTW'(QDEPTH));
    assign cmd_accept      = imem.imem_valid & imem.imem_ready;
    assign push            = cmd_accept & ~imem.imem_wr_en;
    assign wr_accept       = cmd_accept & imem.imem_wr_en;
    assign resp_valid      = (state == RESP);
    assign pop             = resp_valid & imem.imem_dp_ready;

    assign imem.imem_dp_valid     = resp_valid;
    assign imem.imem_dp_read_data = resp_valid ? q_data[rd_ptr] : '0;

    // Out-of-range sizes become "to end of line"; bytes past the line end are never enabled.
    always_comb begin
        if (imem.imem_wr_size == '0 || imem.imem_wr_size > ISIZEW'(NBYTES))
            wr_len = 6'(NBYTES);
        else
            wr_len = imem.imem_wr_size[5:0];
        wr_end     = {2'b00, wr_off} + wr_len;
        wr_shifted = imem.imem_wr_data << {wr_off, 3'b000};
        for (int k = 0; k < NBYTES; k++)
            wr_be[k] = (6'(k) >= {2'b00, wr_off}) && (6'(k) < wr_end);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < NBYTES; k++)
                if (wr_be[k])
                    line_mem[line_idx][8*k +: 8] <= wr_shifted[8*k +: 8];
        end
    end

    // The queue holds a copy of the line, so later writes never leak into pending reads.
    always_ff @(posedge clk) begin
        if (push)
            q_data[wr_ptr] <= line_mem[line_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // After a handshake the counter reloads with the full latency so the next response
    // lands LATENCY cycles after the handshake edge.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    lat_nxt   = LATW'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : COUNT;
                end
            end
            COUNT: begin
                if (lat_cnt <= LATW'(1))
                    state_nxt = RESP;
                else
                    lat_nxt = lat_cnt - 1'b1;
            end
            RESP: begin
                if (imem.imem_dp_ready) begin
                    if (count > CNTW'(1) || push) begin
                        lat_nxt   = LATW'(LATENCY);
                        state_nxt = (LATENCY == 1) ? RESP : COUNT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, byte writes, backpressure, snapshot
// ordering, index wrap and asynchronous reset with pending reads.
module tb_imem_responder;

    localparam logic [127:0] LINE0  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] LINE1  = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
    localparam logic [127:0] LINE2  = 128'h2f2e2d2c_2b2a2928_27262524_23222120;
    localparam logic [127:0] LINE3  = 128'h3f3e3d3c_3b3a3938_37363534_33323130;
    localparam logic [127:0] LINE4  = 128'h4f4e4d4c_4b4a4948_47464544_43424140;
    localparam logic [127:0] LINE2W = 128'h44332211_2b2a2928_27262524_23222120;
    localparam logic [127:0] LINE4W = 128'ha7a6a5a4_a3a2a1a0_47464544_43424140;
    localparam logic [127:0] LINE3W = 128'h3f3e3d3c_3b3a3938_37363534_d3d2d1d0;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    imem_responder_if #(.IDATAW(128), .ISIZEW(8), .IADDRW(32)) bus ();

    imem_responder #(
        .IDATAW(128), .ISIZEW(8), .IADDRW(32),
        .LINES_LOG2(10), .QDEPTH(4), .LATENCY(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .imem (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!bus.imem_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check_output({tag, "_ready_timeout"}, 128'(bus.imem_ready), 128'd1);
    endtask

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr,
                                  input logic [127:0] data, input logic [7:0] size);
        bus.imem_valid   = 1'b1;
        bus.imem_wr_en   = wr;
        bus.imem_address = addr;
        bus.imem_wr_data = data;
        bus.imem_wr_size = size;
        wait_ready("cmd");
        @(posedge clk); #1;
        bus.imem_valid = 1'b0;
        bus.imem_wr_en = 1'b0;
    endtask

    // Waits for dp_valid, checks the wait length and data, then consumes the handshake edge.
    task automatic expect_resp(input logic [127:0] exp_data, input int exp_wait, input string tag);
        int n = 0;
        while (!bus.imem_dp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_wait"}, 128'(n), 128'(exp_wait));
        check_output({tag, "_data"}, bus.imem_dp_read_data, exp_data);
        @(posedge clk); #1;
        check_output({tag, "_drop"}, 128'(bus.imem_dp_valid), 128'd0);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b0;
        bus.imem_valid   = 1'b0;
        bus.imem_wr_en   = 1'b0;
        bus.imem_address = '0;
        bus.imem_wr_data = '0;
        bus.imem_wr_size = '0;
        bus.imem_dp_ready = 1'b1;

        #12;
        check_output("rst_dp_valid", 128'(bus.imem_dp_valid), 128'd0);
        check_output("rst_dp_data", bus.imem_dp_read_data, 128'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check_output("rst_ready", 128'(bus.imem_ready), 128'd1);
        check_output("rst_count", 128'(dut.count), 128'd0);

        // Preload; size 0 and size 17 both mean a full line from offset 0.
        apply_stimulus(1'b1, 32'h00, LINE0, 8'd16);
        apply_stimulus(1'b1, 32'h10, LINE1, 8'd16);
        apply_stimulus(1'b1, 32'h20, LINE2, 8'd16);
        apply_stimulus(1'b1, 32'h30, LINE3, 8'd0);
        apply_stimulus(1'b1, 32'h40, LINE4, 8'd17);

        apply_stimulus(1'b0, 32'h10, '0, '0);
        check_output("lat_valid_accept_cycle", 128'(bus.imem_dp_valid), 128'd0);
        vectors++;
        assert (bus.imem_dp_read_data[31:0] === 32'h0) else begin
            miscompares++;
            $error("[TB] FAIL lat_data_idle: observed %h expected %h", bus.imem_dp_read_data[31:0], 32'h0);
        end
        expect_resp(LINE1, 3, "lat_line1");

        apply_stimulus(1'b1, 32'h2c, 128'h88776655_44332211, 8'd8);
        apply_stimulus(1'b0, 32'h20, '0, '0);
        expect_resp(LINE2W, 3, "wr_partial_line2");

        apply_stimulus(1'b1, 32'h48, 128'hafaeadac_abaaa9a8_a7a6a5a4_a3a2a1a0, 8'd200);
        apply_stimulus(1'b0, 32'h4f, '0, '0);
        expect_resp(LINE4W, 3, "wr_clamp_line4");

        apply_stimulus(1'b0, 32'h30, '0, '0);
        apply_stimulus(1'b1, 32'h30, 128'hd3d2d1d0, 8'd4);
        apply_stimulus(1'b0, 32'h30, '0, '0);
        expect_resp(LINE3, 1, "snap_old_line3");
        expect_resp(LINE3W, 3, "snap_new_line3");

        apply_stimulus(1'b0, 32'h0000_4010, '0, '0);
        expect_resp(LINE1, 3, "wrap_line1");

        bus.imem_dp_ready = 1'b0;
        bus.imem_valid    = 1'b1;
        bus.imem_wr_en    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.imem_address = 32'(i * 16);
            @(posedge clk); #1;
        end
        check_output("bp_ready_full", 128'(bus.imem_ready), 128'd0);
        bus.imem_address = 32'h40;
        for (int i = 0; i < 4; i++) begin
            check_output("bp_hold_valid", 128'(bus.imem_dp_valid), 128'd1);
            check_output("bp_hold_data", bus.imem_dp_read_data, LINE0);
            check_output("bp_hold_ready", 128'(bus.imem_ready), 128'd0);
            @(posedge clk); #1;
        end
        bus.imem_dp_ready = 1'b1;
        expect_resp(LINE0, 0, "bp_line0");
        check_output("bp_ready_reopen", 128'(bus.imem_ready), 128'd1);
        @(posedge clk); #1;
        bus.imem_valid = 1'b0;
        expect_resp(LINE1, 2, "bp_line1");
        expect_resp(LINE2W, 3, "bp_line2");
        expect_resp(LINE3W, 3, "bp_line3");
        expect_resp(LINE4W, 3, "bp_line4");

        bus.imem_dp_ready = 1'b0;
        apply_stimulus(1'b0, 32'h00, '0, '0);
        apply_stimulus(1'b0, 32'h10, '0, '0);
        for (int n = 0; n < 10 && !bus.imem_dp_valid; n++) begin
            @(posedge clk); #1;
        end
        check_output("mrst_pending_valid", 128'(bus.imem_dp_valid), 128'd1);
        #2 reset = 1'b0;
        #1;
        check_output("mrst_valid_async", 128'(bus.imem_dp_valid), 128'd0);
        check_output("mrst_data_async", bus.imem_dp_read_data, 128'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check_output("mrst_ready", 128'(bus.imem_ready), 128'd1);
        check_output("mrst_count", 128'(dut.count), 128'd0);
        bus.imem_dp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_output("mrst_no_stale", 128'(bus.imem_dp_valid), 128'd0);
            @(posedge clk); #1;
        end
        apply_stimulus(1'b0, 32'h20, '0, '0);
        expect_resp(LINE2W, 3, "mrst_retained_line2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-memory command/data-phase protocol that the fetch stage drives.
- Accepts read and write commands. Reads are captured into an in-order pending queue and returned on the data-phase channel after a programmable latency. Writes update the backing line array immediately and produce no response.
- Serves as the instruction memory model for fetch-stage benches, and as the shell for a later icache.

Parameters:
- IDATAW, 128, line/data width in bits (fixed 16-byte line).
- ISIZEW, 8, write size field width.
- IADDRW, 32, address width.
- LINES_LOG2, 10, log2 of number of 16-byte lines in backing array.
- QDEPTH, 4, pending read queue entries (power of 2, >=2).
- LATENCY, 3, cycles from read acceptance to earliest dp_valid (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- imem_valid  in  1  command valid.
- imem_ready  out  1  command ready.
- imem_address  in  IADDRW  byte address.
- imem_wr_en  in  1  1=write, 0=read.
- imem_wr_data  in  IDATAW  write data; byte k at bits [8k+7:8k].
- imem_wr_size  in  ISIZEW  write byte count, 1..16.
- imem_dp_valid  out  1  read data valid.
- imem_dp_ready  in  1  read data accepted.
- imem_dp_read_data  out  IDATAW  read line.

Behaviour:
- Reset (reset=0, async): queue empty, count=0, FSM=IDLE, imem_dp_valid=0, imem_dp_read_data=0, imem_ready=1 after release. Line array contents are not reset (preloaded in simulation).
- Command handshake: accept when imem_valid & imem_ready at a rising edge.
  - imem_ready = (count < QDEPTH) for both reads and writes. There is no same-cycle bypass when full.
- Line index: imem_address[LINES_LOG2+3:4]. Higher bits are ignored, so addresses wrap modulo the array size.
- Read accept: the full line is read from the array in the acceptance cycle and pushed with its data into the queue. Data is therefore a snapshot at acceptance time.
- Read data format: the dword at line byte offset 4k occupies bits [32k+31:32k], little-endian within each dword. Bits imem_address[3:0] are ignored on reads.
- Write accept:
  - Bytes off = imem_address[3:0] .. off+imem_wr_size-1 of the line take wr_data bytes 0..size-1.
  - Bytes past offset 15 are dropped; there is no wrap into the next line.
  - wr_size=0 or >16 is treated as a write of bytes up to end of line, with size clamped to 16.
  - No response; writes do not occupy the queue.
  - A write is visible to reads accepted on any later edge.
- FSM (operates on the queue head):
  - IDLE: if queue nonempty, load lat_cnt=LATENCY-1. If LATENCY=1 go to RESP, else go to COUNT.
  - COUNT: decrement lat_cnt each cycle. When it reaches 1, go to RESP on the next edge.
  - RESP: imem_dp_valid=1 and imem_dp_read_data=head data. Both are held stable until imem_dp_ready.
    - On handshake: pop. If the queue is still nonempty (including a same-edge push), reload lat_cnt and go to COUNT (or stay in RESP if LATENCY=1). Otherwise go to IDLE.
- Timing: a read accepted at edge t into an empty, idle responder has imem_dp_valid high in cycle t+LATENCY. Each subsequent queued read asserts valid LATENCY cycles after the previous dp handshake edge.
- Responses are strictly in acceptance order. A push and a pop on the same edge leaves count unchanged.
- Backpressure: imem_dp_ready low holds RESP indefinitely. Commands continue to be accepted until the queue is full.
- Reset mid-operation: all pending reads are discarded and imem_dp_valid drops asynchronously. Array writes already accepted persist.
- Out of scope: no flush input (requester drops stale responses), no error response.

Test Plan:
- LATENCY=3, read 0x00000010 accepted edge 5, dp_ready=1 -> dp_valid high only in cycle 8. Data = line 1 preload, dword at 0x10 in bits [31:0].
- Write addr 0x0000002C, size 8, data bytes 0x11..0x88 -> bytes 12..15 of line 2 = 0x11,0x22,0x33,0x44. Then a read of 0x20 returns bits [127:96]=0x44332211, bytes 0..11 unchanged, and the other 4 bytes are dropped.
- dp_ready=0, issue 5 back-to-back reads (QDEPTH=4) -> imem_ready low after the 4th accept. The 5th is stalled, and dp_read_data stays stable while dp_valid=1. Raising dp_ready returns lines in order, 3 cycles apart.
- Read A accepted, then a write to A's line before A responds -> A returns pre-write data. A read after the write returns the new data.
- Address 0x00004010 with LINES_LOG2=10 -> returns line 1 (wrap).
- Assert reset low with 2 reads pending and dp_valid=1 -> dp_valid=0 immediately. After release: count=0, imem_ready=1, no stale responses, and previously written data is retained.
